// File: rtl/sram22_pkg.sv
// ============================================================================
// sram22_pkg : shared types and lane-merge helper for the SRAM22 model
// Rev 1.0
// ============================================================================
`default_nettype none

package sram22_pkg;

  typedef enum logic [1:0] {
    RDW_X   = 2'd0,
    RDW_NEW = 2'd1,
    RDW_OLD = 2'd2
  } rdw_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MERGE_MAX_W = 256;

  function automatic logic [MERGE_MAX_W-1:0] lane_merge(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_W-1:0] mask,
    input int                     lane_w
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_w;
    for (int b = 0; b < MERGE_MAX_W; b++) begin
      if (mask[8'(b / lane_w)]) merged[b[7:0]] = new_w[b[7:0]];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram22_out_pipe.sv
// ============================================================================
// sram22_out_pipe : READ_LATENCY-deep data/valid output register chain
// Rev 1.0
// ============================================================================
`default_nettype none

module sram22_out_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  vld_o
);

  logic                  stg_ld;
  logic                  stg_vld;
  logic [DATA_WIDTH-1:0] stg_data;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dv_q;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  ld_q;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        ld_q   <= 1'b0;
        vld_q  <= 1'b0;
        data_q <= '0;
      end else begin
        ld_q  <= ld_i;
        vld_q <= vld_i;
        if (ld_i) data_q <= data_i;
      end
    end

    assign stg_ld   = ld_q;
    assign stg_vld  = vld_q;
    assign stg_data = data_q;
  end else begin : g_lat1
    assign stg_ld   = ld_i;
    assign stg_vld  = vld_i;
    assign stg_data = data_i;
  end

  // Data only moves on a real access so dout holds across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dv_q <= stg_vld;
      if (stg_ld) dout_q <= stg_data;
    end
  end

  assign data_o = dout_q;
  assign vld_o  = dv_q;

endmodule

`default_nettype wire

// File: rtl/sram22_param_model.sv
// ============================================================================
// sram22_param_model : parametrised SRAM22 single-port behavioural model
// Optional post-reset zero-fill sweep enabled by SRAM22_INIT_SWEEP_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sram22_param_model
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int WMASK_WIDTH  = 4,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   busy
);

  localparam int        RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int        LANE_W    = DATA_WIDTH / WMASK_WIDTH;
  localparam rdw_mode_e MODE      = rdw_mode_e'(RDW_MODE);

  if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_chk_mask
    $fatal(1, "DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_chk_rdw
    $fatal(1, "RDW_MODE must be 0, 1 or 2");
  end
  if (DATA_WIDTH > MERGE_MAX_W) begin : g_chk_width
    $fatal(1, "DATA_WIDTH exceeds lane_merge capacity");
  end

  logic                  access;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic                  pipe_vld;
  logic                  sweep_wr;
  logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef SRAM22_INIT_SWEEP_EN
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  sweep_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter wraps to 0 on the final increment, ready for the next sweep.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_wr = 1'b0;
    if (state_q == SWEEP) begin
      sweep_wr = 1'b1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = IDLE;
    end
  end

  assign sweep_addr = cnt_q;
  assign busy       = (state_q == SWEEP);
`else
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH] = '{default: '0};

  assign sweep_wr   = 1'b0;
  assign sweep_addr = '0;
  assign busy       = 1'b0;
`endif

  assign access  = ce & ~busy & ~rst;
  assign rd_word = mem_q[addr];
  assign merged  = DATA_WIDTH'(lane_merge(MERGE_MAX_W'(rd_word), MERGE_MAX_W'(din),
                                          MERGE_MAX_W'(wmask), LANE_W));

  always_ff @(posedge clk) begin
    if (sweep_wr && !rst) begin
      mem_q[sweep_addr] <= '0;
    end else if (access && we) begin
      mem_q[addr] <= merged;
    end
  end

  always_comb begin
    pipe_data = rd_word;
    pipe_vld  = access;
    if (we) begin
      if (MODE == RDW_NEW) begin
        pipe_data = merged;
      end else if (MODE == RDW_OLD) begin
        pipe_data = rd_word;
      end else begin
        pipe_data = 'x;
        pipe_vld  = 1'b0;
      end
    end
  end

  sram22_out_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_out_pipe (
    .clk   (clk),
    .rst   (rst),
    .ld_i  (access),
    .vld_i (pipe_vld),
    .data_i(pipe_data),
    .data_o(dout),
    .vld_o (dout_valid)
  );

endmodule

`default_nettype wire
